arithmetic_logic_unit: RTL and testbench

Registered 8-bit ALU for the 8-bit processor datapath. Each cycle it computes one of five operations (add, subtract, NAND, shift-left, shift-right) on two operands selected by a 4-bit opcode. It registers the result together with zero and negative status flags. Its results and flags feed the register file write-back and the branch/condition logic.

---
 rtl/alu_pkg.sv | 14 +
 rtl/alu_core.sv | 30 +++
 rtl/arithmetic_logic_unit.sv | 43 ++++
 tb/tb_arithmetic_logic_unit.sv | 96 +++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared ALU opcode constants and widths, also used by the instruction decoder.
package alu_pkg;

  localparam int OP_W      = 4;
  localparam int DATA_W    = 8;

  localparam logic [OP_W-1:0] OP_NOP  = 4'h0;
  localparam logic [OP_W-1:0] OP_ADD  = 4'h1;
  localparam logic [OP_W-1:0] OP_SUB  = 4'h2;
  localparam logic [OP_W-1:0] OP_NAND = 4'h3;
  localparam logic [OP_W-1:0] OP_SHL  = 4'h4;
  localparam logic [OP_W-1:0] OP_SHR  = 4'h5;

endpackage

// File: rtl/alu_core.sv
// Combinational ALU datapath: result plus zero/negative flags from the same result.
module alu_core
  import alu_pkg::*;
#(
  parameter int WIDTH = DATA_W
) (
  input  logic [WIDTH-1:0] inA,
  input  logic [WIDTH-1:0] inB,
  input  logic [OP_W-1:0]  opCode,
  output logic [WIDTH-1:0] result,
  output logic             zFlag,
  output logic             nFlag
);

  always_comb begin
    result = '0;
    case (opCode)
      OP_ADD:  result = inA + inB;
      OP_SUB:  result = inA - inB;
      OP_NAND: result = ~(inA & inB);
      OP_SHL:  result = {inA[WIDTH-2:0], 1'b0};
      OP_SHR:  result = {1'b0, inA[WIDTH-1:1]};
      default: result = '0;  // NOP and reserved opcodes
    endcase
  end

  assign zFlag = (result == '0);
  assign nFlag = result[WIDTH-1];

endmodule

// File: rtl/arithmetic_logic_unit.sv
// Registered ALU: one-cycle latency, full throughput, synchronous active-high reset.
module arithmetic_logic_unit
  import alu_pkg::*;
#(
  parameter int WIDTH = DATA_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] inA,
  input  logic [WIDTH-1:0] inB,
  input  logic [OP_W-1:0]  opCode,
  output logic [WIDTH-1:0] out,
  output logic             zOutput,
  output logic             nOutput
);

  logic [WIDTH-1:0] result;
  logic             zFlag;
  logic             nFlag;

  alu_core #(.WIDTH(WIDTH)) uCore (
    .inA    (inA),
    .inB    (inB),
    .opCode (opCode),
    .result (result),
    .zFlag  (zFlag),
    .nFlag  (nFlag)
  );

  // Reset state matches a zero result so downstream condition logic sees Z=1.
  always_ff @(posedge clk) begin
    if (rst) begin
      out     <= '0;
      zOutput <= 1'b1;
      nOutput <= 1'b0;
    end else begin
      out     <= result;
      zOutput <= zFlag;
      nOutput <= nFlag;
    end
  end

endmodule

// File: tb/tb_arithmetic_logic_unit.sv
// Directed self-checking bench for arithmetic_logic_unit.
module tb_arithmetic_logic_unit;
  import alu_pkg::*;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] inA, inB;
  logic [3:0] opCode;
  logic [7:0] out;
  logic       zOutput, nOutput;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  arithmetic_logic_unit #(.WIDTH(8)) dut (
    .clk     (clk),
    .rst     (rst),
    .inA     (inA),
    .inB     (inB),
    .opCode  (opCode),
    .out     (out),
    .zOutput (zOutput),
    .nOutput (nOutput)
  );

  task automatic chk(input string tag, input logic [7:0] eo, input logic ez, input logic en);
    checks++;
    assert ({out, zOutput, nOutput} === {eo, ez, en}) else begin
      errors++;
      $error("FAIL %s: got out=%h z=%b n=%b, expected out=%h z=%b n=%b",
             tag, out, zOutput, nOutput, eo, ez, en);
    end
  endtask

  // Apply inputs away from the edge, then sample just after the capturing edge.
  task automatic step(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b);
    @(negedge clk);
    opCode = op; inA = a; inB = b;
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1; inA = 8'd5; inB = 8'd3; opCode = OP_ADD;
    @(posedge clk); #1; chk("reset_c1", 8'h00, 1'b1, 1'b0);
    @(posedge clk); #1; chk("reset_c2", 8'h00, 1'b1, 1'b0);
    @(negedge clk); rst = 1'b0;
    @(posedge clk); #1; chk("reset_release", 8'd8, 1'b0, 1'b0);

    step(OP_ADD, 8'd1, 8'd2);     chk("add_1_2", 8'd3, 1'b0, 1'b0);
    step(OP_ADD, 8'd4, 8'd4);     chk("add_4_4", 8'd8, 1'b0, 1'b0);
    step(OP_ADD, 8'd128, 8'd4);   chk("add_128_4", 8'd132, 1'b0, 1'b1);
    step(OP_ADD, 8'd128, 8'd128); chk("add_wrap", 8'd0, 1'b1, 1'b0);

    step(OP_SUB, 8'd64, 8'd64);   chk("sub_64_64", 8'd0, 1'b1, 1'b0);
    step(OP_SUB, 8'd128, 8'd32);  chk("sub_128_32", 8'd96, 1'b0, 1'b0);
    step(OP_SUB, 8'd0, 8'd1);     chk("sub_0_1", 8'd255, 1'b0, 1'b1);

    step(OP_NAND, 8'h0C, 8'h0C);  chk("nand_0c", 8'hF3, 1'b0, 1'b1);
    step(OP_NAND, 8'h0F, 8'h0F);  chk("nand_0f", 8'hF0, 1'b0, 1'b1);
    step(OP_NAND, 8'hFF, 8'hFF);  chk("nand_ff", 8'h00, 1'b1, 1'b0);
    step(OP_NAND, 8'hA5, 8'h0F);  chk("nand_a5_0f", 8'hFA, 1'b0, 1'b1);

    step(OP_SHL, 8'hFF, 8'h00);   chk("shl_ff", 8'hFE, 1'b0, 1'b1);
    step(OP_SHL, 8'h7F, 8'hFF);   chk("shl_7f", 8'hFE, 1'b0, 1'b1);
    step(OP_SHL, 8'h80, 8'h5A);   chk("shl_80", 8'h00, 1'b1, 1'b0);
    step(OP_SHL, 8'h41, 8'h00);   chk("shl_41", 8'h82, 1'b0, 1'b1);
    step(OP_SHR, 8'hFF, 8'h00);   chk("shr_ff", 8'h7F, 1'b0, 1'b0);
    step(OP_SHR, 8'h01, 8'hFF);   chk("shr_01", 8'h00, 1'b1, 1'b0);
    step(OP_SHR, 8'h82, 8'hC3);   chk("shr_82", 8'h41, 1'b0, 1'b0);
    step(OP_SHR, 8'h82, 8'h00);   chk("shr_inb_ignored", 8'h41, 1'b0, 1'b0);

    step(OP_NOP, 8'h55, 8'h33);   chk("nop", 8'h00, 1'b1, 1'b0);
    step(4'hA, 8'hF0, 8'h0F);     chk("reserved_a", 8'h00, 1'b1, 1'b0);
    step(4'h6, 8'h80, 8'h80);     chk("reserved_6", 8'h00, 1'b1, 1'b0);
    step(4'hF, 8'hFF, 8'h01);     chk("reserved_f", 8'h00, 1'b1, 1'b0);

    // Mid-cycle input change must not leak to outputs before the next edge.
    step(OP_ADD, 8'd10, 8'd20);   chk("add_10_20", 8'd30, 1'b0, 1'b0);
    #2; opCode = OP_SUB; inA = 8'd0; inB = 8'd1;
    #1; chk("hold_midcycle", 8'd30, 1'b0, 1'b0);
    @(posedge clk); #1; chk("after_change", 8'd255, 1'b0, 1'b1);

    // Reset mid-stream discards the operation sampled at that edge.
    @(negedge clk); rst = 1'b1; opCode = OP_ADD; inA = 8'd7; inB = 8'd7;
    @(posedge clk); #1; chk("reset_midstream", 8'h00, 1'b1, 1'b0);
    @(negedge clk); rst = 1'b0;
    @(posedge clk); #1; chk("post_reset_add", 8'd14, 1'b0, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
